// File: rtl/tone_meter.sv
// Square-wave half-period meter: synchronizes a slow input, times each phase,
// reports high/low/period lengths, lock against an expected half-period, signal loss.
module tone_meter #(
  parameter logic [31:0] EXP_HALF = 32'd10000001,
  parameter logic [31:0] TOL      = 32'd16,
  parameter logic [31:0] TIMEOUT  = 32'd20000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in,
  input  logic        clr,
  output logic [31:0] high_cnt,
  output logic [31:0] low_cnt,
  output logic [31:0] period,
  output logic        meas_valid,
  output logic        locked,
  output logic        timeout,
  output logic [15:0] edge_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HALF,
    RUN,
    LOST
  } state_t;

  state_t      state;
  logic        s1, s2, s3;
  logic [31:0] hcnt;
  logic [31:0] hcnt_inc;
  logic [32:0] psum;
  logic [31:0] period_sat;
  logic        edge_det;
  logic        rise;
  logic        fall;
  logic        lock_nxt;

  function automatic logic in_tol(input logic [31:0] v);
    logic [31:0] d;
    d = (v >= EXP_HALF) ? (v - EXP_HALF) : (EXP_HALF - v);
    return d <= TOL;
  endfunction

  assign edge_det   = s2 ^ s3;
  assign rise       = edge_det & s2;
  assign fall       = edge_det & ~s2;
  assign hcnt_inc   = (&hcnt) ? hcnt : hcnt + 32'd1;
  assign psum       = {1'b0, high_cnt} + {1'b0, hcnt};
  assign period_sat = psum[32] ? 32'hFFFF_FFFF : psum[31:0];
  assign lock_nxt   = (state == RUN) && in_tol(high_cnt)
                      && in_tol(low_cnt);

  // Synchronizer idles high so reset never fakes an edge on an idle line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hcnt       <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
      edge_cnt   <= '0;
    end else if (clr) begin
      state      <= IDLE;
      hcnt       <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
      edge_cnt   <= '0;
    end else begin
      hcnt       <= edge_det ? 32'd1 : hcnt_inc;
      meas_valid <= 1'b0;
      locked     <= lock_nxt;
      if (edge_det)
        edge_cnt <= edge_cnt + 16'd1;
      unique case (state)
        IDLE: begin
          if (edge_det)
            state <= ARM;
        end
        ARM, HALF, RUN: begin
          if (edge_det) begin
            if (fall)
              high_cnt <= hcnt;
            else
              low_cnt <= hcnt;
            // ARM has no trusted high phase yet, so no period there.
            if (rise && state != ARM) begin
              period     <= period_sat;
              meas_valid <= 1'b1;
            end
            state <= (state == ARM) ? HALF : RUN;
          end else if (hcnt == TIMEOUT) begin
            state   <= LOST;
            timeout <= 1'b1;
          end
        end
        LOST: begin
          if (edge_det) begin
            state   <= ARM;
            timeout <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tone_meter.md
TONE_METER -- requirements
Module: tone_meter

Interface
REQ-001 SHALL have parameter EXP_HALF, default 10000001, the expected half-period in clk cycles.
REQ-002 SHALL have parameter TOL, default 16, the allowed |measured - EXP_HALF| for lock.
REQ-003 SHALL have parameter TIMEOUT, default 20000000, the number of clk cycles without an edge that declares signal loss.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in  input  1  asynchronous square-wave input; idles high.
REQ-007 clr  input  1  synchronous clear of measurement state.
REQ-008 high_cnt  output  32  last measured high-phase length in cycles.
REQ-009 low_cnt  output  32  last measured low-phase length in cycles.
REQ-010 period  output  32  last full period, high + low.
REQ-011 meas_valid  output  1  one-cycle pulse when period updates.
REQ-012 locked  output  1  both last half-periods within tolerance.
REQ-013 timeout  output  1  sticky signal-loss flag.
REQ-014 edge_cnt  output  16  count of detected edges; wraps.

Function
REQ-015 SHALL pass in through a two-flop synchronizer (s1, s2), followed by a history flop s3.
REQ-016 An edge is s2 != s3: rising when s2=1, falling when s2=0.
REQ-017 An edge SHALL be acted on 3 rising clk edges after in is first sampled at its new level.
REQ-018 Phase counter hcnt SHALL load 1 on an edge, otherwise increment, and saturate at 32'hFFFFFFFF.
REQ-019 Capture rule, applied in states ARM, HALF and RUN only: on a falling edge high_cnt <= hcnt; on a rising edge low_cnt <= hcnt.
REQ-020 The FSM SHALL have states IDLE, ARM, HALF, RUN and LOST.
REQ-021 IDLE: any edge -> ARM; no capture, no timeout check.
REQ-022 ARM: edge -> capture, then HALF.
REQ-023 HALF: edge -> capture, then RUN; if the edge is rising, also update period.
REQ-024 RUN: edge -> capture; if the edge is rising, update period.
REQ-025 Period update: period <= high_cnt + hcnt, saturating at all-ones; meas_valid=1 in the following cycle only.
REQ-026 In ARM, HALF or RUN, hcnt == TIMEOUT with no edge in that cycle -> LOST, timeout <= 1.
REQ-027 LOST: hcnt keeps counting (saturating); an edge -> ARM, timeout <= 0, no capture.
REQ-028 locked SHALL be registered, equal to (state==RUN) && |high_cnt-EXP_HALF|<=TOL && |low_cnt-EXP_HALF|<=TOL, evaluated with unsigned-safe difference; locked is therefore 1 cycle behind the captures.
REQ-029 edge_cnt SHALL increment on every detected edge in every state, wrapping FFFF->0000.
REQ-030 clr=1 SHALL force IDLE and zero hcnt, high_cnt, low_cnt, period, meas_valid, locked, timeout and edge_cnt; synchronizer flops are unaffected.
REQ-031 clr SHALL take priority over a coincident edge; that edge is discarded and not counted.
REQ-032 An edge coinciding with hcnt == TIMEOUT SHALL be treated as an edge; no timeout is raised.

Reset
REQ-033 reset=0 SHALL asynchronously set s1, s2, s3 to 1, state to IDLE, hcnt to 0, and all outputs to 0.
REQ-034 Deassertion mid-waveform SHALL restart from IDLE; the first post-reset edge only arms the meter.

Verification
REQ-035 Reset, in held 1 for 10^5 cycles -> all outputs 0, no meas_valid, timeout=0 (IDLE).
REQ-036 Wave high 100 / low 60 cycles -> high_cnt=100, low_cnt=60, period=160, one meas_valid per rising edge from the first full period, locked=0.
REQ-037 EXP_HALF=50, TOL=2: wave 51/49 -> locked=1 in RUN; then high 53 -> locked=0 one cycle after capture.
REQ-038 TIMEOUT=1000: stop toggling -> timeout=1 when hcnt reaches 1000, state LOST; next edge -> timeout=0, ARM, no meas_valid until a full period is captured again.
REQ-039 clr asserted in the same cycle an edge is detected -> IDLE, edge_cnt=0, edge ignored; edge_cnt wraps 65535->0 under sustained toggling.
REQ-040 reset pulsed mid-high-phase -> outputs 0 immediately, then correct measurements resume per REQ-034.
